// File: rtl/alu_pipe_hs.sv
// Three-stage valid/ready ALU pipeline (capture, compute, output) with a global stall.
// Define ALU_PIPE_MUL_EN to build the multiplier for opcode 8; otherwise opcode 8 is illegal.
module alu_pipe_hs #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(5);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(6);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(7);
`ifdef ALU_PIPE_MUL_EN
  localparam logic [OPW-1:0] OP_MUL  = OPW'(8);
`endif
  localparam logic [OPW-1:0] OP_PASS = OPW'(9);

  // Handshake: a beat moves on a cycle where valid and ready are both 1.
  // The only stall source is a held output (out_valid & ~out_ready); it freezes
  // every stage at once, so in_ready is simply its inverse.
  logic stall;
  logic advance;

  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = advance;

  logic             s1_valid;
  logic [OPW-1:0]   s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= opcode;
        s1_a  <= a;
        s1_b  <= b;
      end
    end
  end

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] c_y;
  logic [3:0]       c_flags;
  logic             c_illegal;
  logic             c_ovf;
  logic             c_carry;

  assign add_full = {1'b0, s1_a} + {1'b0, s1_b};
  assign sub_full = {1'b0, s1_a} - {1'b0, s1_b};

`ifdef ALU_PIPE_MUL_EN
  logic [WIDTH-1:0] mul_lo;
  assign mul_lo = s1_a * s1_b;
`endif

  always_comb begin
    c_y       = '0;
    c_illegal = 1'b0;
    c_ovf     = 1'b0;
    c_carry   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        c_y     = add_full[WIDTH-1:0];
        c_carry = add_full[WIDTH];
        c_ovf   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (add_full[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        // sub_full[WIDTH] is the unsigned borrow (a < b)
        c_y     = sub_full[WIDTH-1:0];
        c_carry = sub_full[WIDTH];
        c_ovf   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (sub_full[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_AND:  c_y = s1_a & s1_b;
      OP_OR:   c_y = s1_a | s1_b;
      OP_XOR:  c_y = s1_a ^ s1_b;
      OP_NOT:  c_y = ~s1_a;
      OP_SHL:  c_y = s1_a << s1_b[SHW-1:0];
      OP_SHR:  c_y = s1_a >> s1_b[SHW-1:0];
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:  c_y = mul_lo;
`endif
      OP_PASS: c_y = s1_b;
      default: c_illegal = 1'b1;
    endcase
    c_flags = {c_illegal, c_ovf, c_carry, (c_y == '0)};
  end

  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  logic [3:0]       s2_flags;

  // Data registers load only with a valid beat so bubbles never disturb y/flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_flags <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y     <= c_y;
        s2_flags <= c_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      y         <= '0;
      flags     <= '0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        y     <= s2_y;
        flags <= s2_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Directed bench for alu_pipe_hs (WIDTH=8): latency, flags, backpressure ordering, reset.
// Expected MUL result depends on whether ALU_PIPE_MUL_EN is defined for the build.
module tb_alu_pipe_hs;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [3:0] flags;

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_q[$];

  alu_pipe_hs #(.WIDTH(8), .OPW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; a = '0; b = '0;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passes++;
    checks++;
    if (y !== 8'h00) $display("FAIL reset_y: got %h want 00", y); else passes++;
    checks++;
    if (flags !== 4'h0) $display("FAIL reset_flags: got %b want 0000", flags); else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passes++;
    step();
  endtask

  // One beat through an idle pipe; checks acceptance, 3-cycle latency and the result.
  task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] ey, input logic [3:0] ef);
    out_ready = 1'b1; opcode = op; a = av; b = bv; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL %s_in_ready: got %b want 1", name, in_ready); else passes++;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL %s_early_valid: got %b want 0", name, out_valid); else passes++;
    step();
    checks++;
    if (out_valid !== 1'b1) $display("FAIL %s_out_valid: got %b want 1", name, out_valid); else passes++;
    checks++;
    if (y !== ey) $display("FAIL %s_y: got %h want %h", name, y, ey); else passes++;
    checks++;
    if (flags !== ef) $display("FAIL %s_flags: got %b want %b", name, flags, ef); else passes++;
    step();
  endtask

  task automatic test_add();
    run_op("add_f0_20", 4'd0, 8'hF0, 8'h20, 8'h10, 4'b0010);
  endtask

  task automatic test_sub();
    run_op("sub_80_01", 4'd1, 8'h80, 8'h01, 8'h7F, 4'b0100);
    run_op("sub_05_05", 4'd1, 8'h05, 8'h05, 8'h00, 4'b0001);
  endtask

  task automatic test_mul();
`ifdef ALU_PIPE_MUL_EN
    run_op("mul_12_10", 4'd8, 8'h12, 8'h10, 8'h20, 4'b0000);
`else
    run_op("mul_12_10", 4'd8, 8'h12, 8'h10, 8'h00, 4'b1001);
`endif
  endtask

  task automatic test_shift_illegal();
    run_op("shl_81_1", 4'd6, 8'h81, 8'h01, 8'h02, 4'b0000);
    run_op("shr_81_0", 4'd7, 8'h81, 8'h08, 8'h81, 4'b0000);
    run_op("illegal_f", 4'hF, 8'h33, 8'h44, 8'h00, 4'b1001);
  endtask

  task automatic test_logic();
    run_op("not_5a", 4'd5, 8'h5A, 8'h00, 8'hA5, 4'b0000);
    run_op("xor_ff_ff", 4'd4, 8'hFF, 8'hFF, 8'h00, 4'b0001);
    run_op("pass_b", 4'd9, 8'h11, 8'hC3, 8'hC3, 4'b0000);
  endtask

  // Five ADD beats back to back; the first result is held for 4 cycles.
  task automatic test_back_to_back();
    int sent;
    int rcvd;
    int stall_left;
    logic [7:0] exp_y;
    sent = 0; rcvd = 0; stall_left = 4;
    exp_q.delete();
    opcode = 4'd0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && rcvd < 5; cyc++) begin
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (sent < 5);
      a = 8'(sent + 1);
      b = 8'(sent + 1);
      #1;
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) $display("FAIL b2b_stall_in_ready: got %b want 0", in_ready); else passes++;
        checks++;
        if (y !== 8'h02) $display("FAIL b2b_stall_y: got %h want 02", y); else passes++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(8'(2 * (sent + 1)));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_extra_result: got %h want none", y);
        end else begin
          exp_y = exp_q.pop_front();
          if (y !== exp_y) $display("FAIL b2b_result: got %h want %h", y, exp_y); else passes++;
        end
        rcvd++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (rcvd != 5) $display("FAIL b2b_count: got %0d want 5", rcvd); else passes++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); else passes++;
    checks++;
    if (stall_left != 0) $display("FAIL b2b_stall_cycles: got %0d left want 0", stall_left); else passes++;
    step();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_duplicate: got %b want 0", out_valid); else passes++;
  endtask

  task automatic test_reset_midstream();
    int stale;
    out_ready = 1'b1; opcode = 4'd0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 8'(8'h10 + i);
      b = 8'h01;
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid); else passes++;
    checks++;
    if (y !== 8'h00) $display("FAIL midrst_y: got %h want 00", y); else passes++;
    checks++;
    if (flags !== 4'h0) $display("FAIL midrst_flags: got %b want 0000", flags); else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", in_ready); else passes++;
    stale = 0;
    repeat (6) begin
      step();
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) $display("FAIL midrst_stale: got %0d results want 0", stale); else passes++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_shift_illegal();
    test_logic();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
